comparator_driver: RTL and testbench

Initiator for the bit-serial `Comparator` load/op protocol. It accepts two WIDTH-bit operands on a valid/ready request port and sequences the comparator: clear, load, settle wait, op strobe. It then samples L/E/G and returns the result on a valid/ready response port. It sits between the datapath control and a `Comparator` instance, so no other logic has to hand-time `load`/`op`.

---
 rtl/comparator_pkg.sv | 23 ++
 rtl/comparator_driver_if.sv | 48 ++++
 rtl/comparator_driver_cycle_timer.sv | 36 +++
 rtl/comparator_driver.sv | 122 ++++++++++++
 tb/tb_comparator_driver.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/comparator_pkg.sv
// Shared definitions for the bit-serial Comparator driver and its benches:
// default geometry, FSM state type and the flag-consistency helper.
package comparator_pkg;

  localparam int CMP_WIDTH       = 32;
  localparam int CMP_WAIT_CYCLES = 34;
  localparam int CMP_OP_CYCLES   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_WAIT,
    ST_OP,
    ST_RESP
  } cmp_state_e;

  // A well-behaved comparator raises exactly one of L/E/G.
  function automatic logic flags_onehot(input logic l, input logic e, input logic g);
    return (l & ~e & ~g) | (~l & e & ~g) | (~l & ~e & g);
  endfunction

endpackage

// File: rtl/comparator_driver_if.sv
// Request, response and comparator-side signals of the comparator driver.
// The driver connects through the slave modport; the surrounding logic uses master.
interface comparator_driver_if
  import comparator_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;

  logic             cmp_res;
  logic             cmp_load;
  logic             cmp_op;
  logic [WIDTH-1:0] cmp_a;
  logic [WIDTH-1:0] cmp_b;
  logic             cmp_L;
  logic             cmp_E;
  logic             cmp_G;

  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_lt;
  logic             rsp_eq;
  logic             rsp_gt;
  logic             rsp_err;

  modport slave (
    input  req_valid, req_a, req_b,
    input  cmp_L, cmp_E, cmp_G,
    input  rsp_ready,
    output req_ready,
    output cmp_res, cmp_load, cmp_op, cmp_a, cmp_b,
    output rsp_valid, rsp_lt, rsp_eq, rsp_gt, rsp_err
  );

  modport master (
    output req_valid, req_a, req_b,
    output cmp_L, cmp_E, cmp_G,
    output rsp_ready,
    input  req_ready,
    input  cmp_res, cmp_load, cmp_op, cmp_a, cmp_b,
    input  rsp_valid, rsp_lt, rsp_eq, rsp_gt, rsp_err
  );

endinterface

// File: rtl/comparator_driver_cycle_timer.sv
// Loadable down-counter shared by the WAIT and OP phases; done_o is high
// during the final cycle of a loaded interval (count of zero).
module cycle_timer #(
  parameter int CNT_W = 1
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Saturates at zero rather than wrapping; every phase entry reloads it.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/comparator_driver.sv
// Sequences a bit-serial Comparator through clear, load, settle and op,
// then returns the sampled L/E/G flags on a valid/ready response port.
module comparator_driver
  import comparator_pkg::*;
#(
  parameter int WIDTH       = CMP_WIDTH,
  parameter int WAIT_CYCLES = CMP_WAIT_CYCLES,
  parameter int OP_CYCLES   = CMP_OP_CYCLES
) (
  input  logic               clk,
  input  logic               res,
  comparator_driver_if.slave bus
);

  localparam int CNT_MAX = (WAIT_CYCLES > OP_CYCLES) ? WAIT_CYCLES : OP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // The timer reports done on its zero count, so an N-cycle phase loads N-1.
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] OP_LOAD   = CNT_W'(OP_CYCLES - 1);

  cmp_state_e       state_q;
  logic             cmp_load_q;
  logic             cmp_op_q;
  logic [WIDTH-1:0] cmp_a_q;
  logic [WIDTH-1:0] cmp_b_q;
  logic             rsp_valid_q;
  logic             rsp_lt_q;
  logic             rsp_eq_q;
  logic             rsp_gt_q;
  logic             rsp_err_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  assign tmr_load = (state_q == ST_LOAD) || ((state_q == ST_WAIT) && tmr_done);
  assign tmr_val  = (state_q == ST_LOAD) ? WAIT_LOAD : OP_LOAD;

  cycle_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk       (clk),
    .res       (res),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .done_o    (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state_q     <= ST_IDLE;
      cmp_load_q  <= 1'b0;
      cmp_op_q    <= 1'b0;
      cmp_a_q     <= '0;
      cmp_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
      rsp_gt_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cmp_a_q <= bus.req_a;
            cmp_b_q <= bus.req_b;
            state_q <= ST_CLR;
          end
        end
        ST_CLR: begin
          cmp_load_q <= 1'b1;
          state_q    <= ST_LOAD;
        end
        ST_LOAD: begin
          cmp_load_q <= 1'b0;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_done) begin
            cmp_op_q <= 1'b1;
            state_q  <= ST_OP;
          end
        end
        ST_OP: begin
          // Flags are reported raw; rsp_err only marks an inconsistent set.
          if (tmr_done) begin
            cmp_op_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_lt_q    <= bus.cmp_L;
            rsp_eq_q    <= bus.cmp_E;
            rsp_gt_q    <= bus.cmp_G;
            rsp_err_q   <= ~flags_onehot(bus.cmp_L, bus.cmp_E, bus.cmp_G);
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE) && !res;
  assign bus.cmp_res   = res || (state_q == ST_CLR);
  assign bus.cmp_load  = cmp_load_q;
  assign bus.cmp_op    = cmp_op_q;
  assign bus.cmp_a     = cmp_a_q;
  assign bus.cmp_b     = cmp_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_lt    = rsp_lt_q;
  assign bus.rsp_eq    = rsp_eq_q;
  assign bus.rsp_gt    = rsp_gt_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_comparator_driver.sv
// Directed bench for comparator_driver: default-parameter instance plus a
// WAIT_CYCLES=1/OP_CYCLES=1 instance, each fed by a behavioural comparator.
module tb_comparator_driver;
  import comparator_pkg::*;

  localparam int W = CMP_WIDTH;

  localparam logic [W-1:0] V_LO = 32'h4444_4444;
  localparam logic [W-1:0] V_HI = 32'h4446_4444;

  logic clk = 1'b0;
  logic res;
  int   checks   = 0;
  int   failures = 0;
  int   fmode    = 0;

  always #5 clk = ~clk;

  comparator_driver_if #(.WIDTH(W)) bus  ();
  comparator_driver_if #(.WIDTH(W)) bus1 ();

  comparator_driver #(
    .WIDTH(W), .WAIT_CYCLES(CMP_WAIT_CYCLES), .OP_CYCLES(CMP_OP_CYCLES)
  ) dut (
    .clk(clk), .res(res), .bus(bus)
  );

  comparator_driver #(
    .WIDTH(W), .WAIT_CYCLES(1), .OP_CYCLES(1)
  ) dut1 (
    .clk(clk), .res(res), .bus(bus1)
  );

  // Behavioural comparator; fmode 1 forces L=G=1, fmode 2 forces no flag.
  always_comb begin
    bus.cmp_L = 1'b0;
    bus.cmp_E = 1'b0;
    bus.cmp_G = 1'b0;
    case (fmode)
      1: begin
        bus.cmp_L = 1'b1;
        bus.cmp_G = 1'b1;
      end
      2: ;
      default: begin
        bus.cmp_L = (bus.cmp_a <  bus.cmp_b);
        bus.cmp_E = (bus.cmp_a == bus.cmp_b);
        bus.cmp_G = (bus.cmp_a >  bus.cmp_b);
      end
    endcase
  end

  always_comb begin
    bus1.cmp_L = (bus1.cmp_a <  bus1.cmp_b);
    bus1.cmp_E = (bus1.cmp_a == bus1.cmp_b);
    bus1.cmp_G = (bus1.cmp_a >  bus1.cmp_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with rsp_ready=1, report latency to rsp_valid and flags.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [3:0] fl);
    bus.rsp_ready = 1'b1;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    lat = -1;
    fl  = 4'bxxxx;
    for (int k = 0; k < 100; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        fl  = {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err};
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic test_reset();
    res = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.req_ready, bus.cmp_res} !== 2'b01) begin
      failures++;
      $display("FAIL reset_ctrl: req_ready,cmp_res=%b required 01", {bus.req_ready, bus.cmp_res});
    end
    checks++;
    if ({bus.cmp_load, bus.cmp_op, bus.rsp_valid, bus.rsp_lt, bus.rsp_eq, bus.rsp_gt,
         bus.rsp_err, bus.cmp_a, bus.cmp_b} !== '0) begin
      failures++;
      $display("FAIL reset_regs: load=%b op=%b rv=%b flags=%b%b%b%b a=%h b=%h required all 0",
               bus.cmp_load, bus.cmp_op, bus.rsp_valid, bus.rsp_lt, bus.rsp_eq, bus.rsp_gt,
               bus.rsp_err, bus.cmp_a, bus.cmp_b);
    end
    res = 1'b0;
    tick();
    checks++;
    if ({bus.req_ready, bus.cmp_res, bus1.req_ready} !== 3'b101) begin
      failures++;
      $display("FAIL reset_release: req_ready,cmp_res,req_ready1=%b required 101",
               {bus.req_ready, bus.cmp_res, bus1.req_ready});
    end
  endtask

  task automatic test_lt_timing();
    int rv_at;
    int res_bad;
    int load_bad;
    int op_bad;
    logic [3:0] fl;
    rv_at = -1;
    res_bad = 0;
    load_bad = 0;
    op_bad = 0;
    fl = 4'bxxxx;
    bus.rsp_ready = 1'b1;
    bus.req_a     = V_LO;
    bus.req_b     = V_HI;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (bus.cmp_res  !== (k == 0)) res_bad++;
      if (bus.cmp_load !== (k == 1)) load_bad++;
      if (bus.cmp_op   !== (k == 36 || k == 37)) op_bad++;
      if (bus.rsp_valid === 1'b1 && rv_at < 0) begin
        rv_at = k;
        fl = {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err};
      end
      tick();
    end
    checks++;
    if (rv_at !== 38) begin
      failures++;
      $display("FAIL lt_latency: rsp_valid at cycle %0d required 38", rv_at);
    end
    checks++;
    if (fl !== 4'b1000) begin
      failures++;
      $display("FAIL lt_flags: lt,eq,gt,err=%b required 1000", fl);
    end
    checks++;
    if ({res_bad, load_bad, op_bad} !== '0) begin
      failures++;
      $display("FAIL strobe_timing: bad cycles res=%0d load=%0d op=%0d required 0 0 0",
               res_bad, load_bad, op_bad);
    end
    checks++;
    if ({bus.cmp_a, bus.cmp_b} !== {V_LO, V_HI}) begin
      failures++;
      $display("FAIL operand_hold: cmp_a=%h cmp_b=%h required %h %h", bus.cmp_a, bus.cmp_b, V_LO, V_HI);
    end
  endtask

  task automatic test_back_to_back();
    int hs;
    int acc;
    int lat2;
    logic [3:0] fl1;
    logic [3:0] fl2;
    logic [W-1:0] a_mid;
    hs = -1;
    acc = -1;
    lat2 = -1;
    fl1 = 4'bxxxx;
    fl2 = 4'bxxxx;
    a_mid = '0;
    bus.rsp_ready = 1'b1;
    bus.req_a     = V_LO;
    bus.req_b     = V_LO;
    bus.req_valid = 1'b1;
    tick();
    bus.req_a = V_HI;
    bus.req_b = V_LO;
    for (int k = 0; k < 100; k++) begin
      if (k == 5) a_mid = bus.cmp_a;
      if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1 && hs < 0) begin
        hs  = k + 1;
        fl1 = {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err};
      end else if (hs >= 0 && bus.req_ready === 1'b1) begin
        acc = k + 1;
        break;
      end
      tick();
    end
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat2 = k;
        fl2 = {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err};
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (a_mid !== V_LO) begin
      failures++;
      $display("FAIL busy_ignore: cmp_a mid-flight=%h required %h", a_mid, V_LO);
    end
    checks++;
    if (fl1 !== 4'b0100 || hs !== 39) begin
      failures++;
      $display("FAIL eq_result: flags=%b hs_edge=%0d required 0100 39", fl1, hs);
    end
    checks++;
    if (acc - hs !== 1) begin
      failures++;
      $display("FAIL b2b_gap: accept-handshake=%0d required 1", acc - hs);
    end
    checks++;
    if (lat2 !== 38 || fl2 !== 4'b0010) begin
      failures++;
      $display("FAIL gt_result: lat=%0d flags=%b required 38 0010", lat2, fl2);
    end
  endtask

  task automatic test_stall();
    int lat;
    int bad;
    logic [3:0] fl;
    lat = -1;
    bad = 0;
    fl = 4'bxxxx;
    bus.rsp_ready = 1'b0;
    bus.req_a     = V_LO;
    bus.req_b     = V_HI;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus.rsp_valid === 1'b1) begin
        lat = k;
        fl = {bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err};
        break;
      end
      tick();
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 3) begin
        bus.req_a = V_HI;
        bus.req_b = V_LO;
        bus.req_valid = 1'b1;
      end else begin
        bus.req_valid = 1'b0;
      end
      tick();
      if ({bus.rsp_valid, bus.rsp_lt, bus.rsp_eq, bus.rsp_gt, bus.rsp_err} !== {1'b1, fl}
          || bus.req_ready !== 1'b0) bad++;
    end
    checks++;
    if (lat !== 38 || fl !== 4'b1000) begin
      failures++;
      $display("FAIL stall_result: lat=%0d flags=%b required 38 1000", lat, fl);
    end
    checks++;
    if (bad !== 0 || bus.cmp_a !== V_LO) begin
      failures++;
      $display("FAIL stall_hold: unstable cycles=%0d cmp_a=%h required 0 %h", bad, bus.cmp_a, V_LO);
    end
    bus.rsp_ready = 1'b1;
    tick();
    checks++;
    if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL stall_release: rsp_valid,req_ready=%b required 01", {bus.rsp_valid, bus.req_ready});
    end
    tick();
    tick();
    tick();
    checks++;
    if ({bus.req_ready, bus.cmp_res, bus.cmp_load} !== 3'b100) begin
      failures++;
      $display("FAIL no_queue: req_ready,cmp_res,cmp_load=%b required 100",
               {bus.req_ready, bus.cmp_res, bus.cmp_load});
    end
  endtask

  task automatic test_err_flags();
    int lat;
    logic [3:0] fl;
    fmode = 1;
    run_txn(V_LO, V_HI, lat, fl);
    checks++;
    if (lat !== 38 || fl !== 4'b1011) begin
      failures++;
      $display("FAIL err_two_flags: lat=%0d flags=%b required 38 1011", lat, fl);
    end
    fmode = 2;
    run_txn(V_LO, V_LO, lat, fl);
    checks++;
    if (lat !== 38 || fl !== 4'b0001) begin
      failures++;
      $display("FAIL err_no_flags: lat=%0d flags=%b required 38 0001", lat, fl);
    end
    fmode = 0;
  endtask

  task automatic test_reset_mid();
    int rv_cnt;
    int lat;
    logic [3:0] fl;
    rv_cnt = 0;
    bus.rsp_ready = 1'b1;
    bus.req_a     = V_HI;
    bus.req_b     = V_LO;
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    res = 1'b1;
    tick();
    checks++;
    if ({bus.req_ready, bus.cmp_res, bus.rsp_valid, bus.cmp_op, bus.cmp_load} !== 5'b01000) begin
      failures++;
      $display("FAIL mid_reset: ready,cres,rv,op,load=%b required 01000",
               {bus.req_ready, bus.cmp_res, bus.rsp_valid, bus.cmp_op, bus.cmp_load});
    end
    res = 1'b0;
    tick();
    checks++;
    if ({bus.req_ready, bus.cmp_res} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset_idle: req_ready,cmp_res=%b required 10", {bus.req_ready, bus.cmp_res});
    end
    for (int k = 0; k < 50; k++) begin
      if (bus.rsp_valid === 1'b1) rv_cnt++;
      tick();
    end
    checks++;
    if (rv_cnt !== 0) begin
      failures++;
      $display("FAIL mid_reset_discard: rsp_valid cycles=%0d required 0", rv_cnt);
    end
    run_txn(V_HI, V_LO, lat, fl);
    checks++;
    if (lat !== 38 || fl !== 4'b0010) begin
      failures++;
      $display("FAIL post_reset_txn: lat=%0d flags=%b required 38 0010", lat, fl);
    end
  endtask

  task automatic test_short_params();
    int lat;
    logic [3:0] fl;
    lat = -1;
    fl = 4'bxxxx;
    bus1.rsp_ready = 1'b1;
    bus1.req_a     = V_HI;
    bus1.req_b     = V_HI;
    bus1.req_valid = 1'b1;
    tick();
    bus1.req_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus1.rsp_valid === 1'b1) begin
        lat = k;
        fl = {bus1.rsp_lt, bus1.rsp_eq, bus1.rsp_gt, bus1.rsp_err};
        break;
      end
      tick();
    end
    tick();
    checks++;
    if (lat !== 4 || fl !== 4'b0100) begin
      failures++;
      $display("FAIL short_params: lat=%0d flags=%b required 4 0100", lat, fl);
    end
    checks++;
    if ({bus1.rsp_valid, bus1.req_ready} !== 2'b01) begin
      failures++;
      $display("FAIL short_handshake: rsp_valid,req_ready=%b required 01", {bus1.rsp_valid, bus1.req_ready});
    end
  endtask

  initial begin
    res = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.rsp_ready  = 1'b0;
    bus1.req_valid = 1'b0;
    bus1.req_a     = '0;
    bus1.req_b     = '0;
    bus1.rsp_ready = 1'b0;
    test_reset();
    test_lt_timing();
    test_back_to_back();
    test_stall();
    test_err_flags();
    test_reset_mid();
    test_short_params();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
